// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: sizes, register offsets,
// CTRL bit positions and FSM state encodings.
package irq_controller_pkg;

   localparam int N_SRC = 8;
   localparam int VEC_W = 3;

   localparam logic [7:0] DEF_BASE_ADDR = 8'h10;

   // Register offsets from BASE_ADDR
   localparam logic [7:0] OFF_MASK    = 8'd0;
   localparam logic [7:0] OFF_PENDING = 8'd1;
   localparam logic [7:0] OFF_CTRL    = 8'd2;

   // CTRL register bit positions
   localparam int CTRL_GIE     = 0;
   localparam int CTRL_IN_SVC  = 1;
   localparam int CTRL_VEC_LSB = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Bundle of the peripheral flag lines, the 8-bit IO bus and the CPU
// irq/ack/done handshake. The controller is the slave side.
interface irq_controller_if;
   import irq_controller_pkg::*;

   logic [N_SRC-1:0] src_flag;
   logic [N_SRC-1:0] src_clr;
   logic [7:0]       address;
   logic [7:0]       din;
   logic             w_en;
   logic             r_en;
   logic [7:0]       dout;
   logic             irq;
   logic [VEC_W-1:0] irq_vec;
   logic             irq_ack;
   logic             irq_done;

   modport master (
      output src_flag, address, din, w_en, r_en, irq_ack, irq_done,
      input  src_clr, dout, irq, irq_vec
   );

   modport slave (
      input  src_flag, address, din, w_en, r_en, irq_ack, irq_done,
      output src_clr, dout, irq, irq_vec
   );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-wins priority encoder with an any-valid flag. Purely
// combinational so it can be reused wherever a fixed-priority pick is needed.
module irq_controller_prio_enc #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: MASK/PENDING/CTRL registers on the IO bus, a
// three-state request FSM towards the CPU, and one-cycle flag-clear pulses
// back to the serviced peripheral.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic            clk,
   input  logic            rst_n,
   irq_controller_if.slave bus
);

   localparam logic [7:0] ADDR_MASK    = BASE_ADDR + OFF_MASK;
   localparam logic [7:0] ADDR_PENDING = BASE_ADDR + OFF_PENDING;
   localparam logic [7:0] ADDR_CTRL    = BASE_ADDR + OFF_CTRL;

   state_t           state_q, state_d;
   logic             irq_q, irq_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [N_SRC-1:0] clr_q, clr_d;

   logic [N_SRC-1:0] mask_q;
   logic             gie_q;
   logic [7:0]       dout_q;

   logic [N_SRC-1:0] pend;
   logic [VEC_W-1:0] sel;
   logic             any_pend;
   logic             in_service;
   logic [7:0]       ctrl_rd;

   assign pend       = bus.src_flag & mask_q;
   assign in_service = (state_q == ST_SVC);

   always_comb begin
      ctrl_rd                                 = '0;
      ctrl_rd[CTRL_GIE]                       = gie_q;
      ctrl_rd[CTRL_IN_SVC]                    = in_service;
      ctrl_rd[CTRL_VEC_LSB +: VEC_W]          = vec_q;
   end

   irq_controller_prio_enc #(
      .N (N_SRC),
      .W (VEC_W)
   ) u_prio_enc (
      .req   (pend),
      .idx   (sel),
      .valid (any_pend)
   );

   // Next-state and registered-output decisions of the request FSM.
   always_comb begin
      state_d = state_q;
      irq_d   = irq_q;
      vec_d   = vec_q;
      clr_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (gie_q && any_pend) begin
               vec_d   = sel;
               irq_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Acknowledge takes priority over a simultaneous withdraw.
            if (bus.irq_ack) begin
               irq_d        = 1'b0;
               clr_d[vec_q] = 1'b1;
               state_d      = ST_SVC;
            end else if (!gie_q || !pend[vec_q]) begin
               irq_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SVC: begin
            if (bus.irq_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and the registered irq, vector and clear-pulse outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset is tested inside the clocked branch, so it is synchronous and only acts on a clock edge.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         irq_q   <= 1'b0;
         vec_q   <= '0;
         clr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         irq_q   <= irq_d;
         vec_q   <= vec_d;
         clr_q   <= clr_d;
      end
   end

   // Register file: MASK and GIE writes, registered read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_q <= '0;
         gie_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         if (bus.w_en) begin
            if (bus.address == ADDR_MASK) mask_q <= bus.din;
            if (bus.address == ADDR_CTRL) gie_q  <= bus.din[CTRL_GIE];
         end
         if (bus.r_en) begin
            case (bus.address)
               ADDR_MASK:    dout_q <= mask_q;
               ADDR_PENDING: dout_q <= pend;
               ADDR_CTRL:    dout_q <= ctrl_rd;
               default:      dout_q <= dout_q;
            endcase
         end
      end
   end

   assign bus.irq     = irq_q;
   assign bus.irq_vec = vec_q;
   assign bus.src_clr = clr_q;
   assign bus.dout    = dout_q;

endmodule
